// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings and the mapping of
// shift levels (shift by 2^i) onto pipeline stages.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  function automatic int stage_of(
    input int level,
    input int stages,
    input int levels
  );
    return (level * stages) / levels;
  endfunction

  function automatic int level_lo(
    input int stage,
    input int stages,
    input int levels
  );
    int lo;
    lo = levels;
    for (int i = levels - 1; i >= 0; i--)
      if (stage_of(i, stages, levels) == stage)
        lo = i;
    return lo;
  endfunction

  function automatic int level_hi(
    input int stage,
    input int stages,
    input int levels
  );
    int hi;
    hi = 0;
    for (int i = 0; i < levels; i++)
      if (stage_of(i, stages, levels) == stage)
        hi = i;
    return hi;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: applies shift levels LEVEL_LO..LEVEL_HI,
// then registers valid/data/shamt/mode/tag/sign on load.
// Ports: clock, reset (async high), flush, load,
// in_* operands from upstream, out_* registered copies.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int TAG_W    = 5,
  parameter  int LEVEL_LO = 0,
  parameter  int LEVEL_HI = 2,
  localparam int SHAMT_W  = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               in_sign,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_mode,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_sign
);

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic             s,
    input int               amt
  );
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    // SRA fill comes from the original operand sign,
    // carried down the pipe rather than the current MSB
    fill = s ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (m)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = (d >> amt) | fill;
      default:  r = (d >> amt) | (d << (WIDTH - amt));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = in_data;
    for (int i = LEVEL_LO; i <= LEVEL_HI; i++)
      if (in_shamt[i])
        shifted = step(shifted, in_mode, in_sign, 1 << i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      out_valid <= 1'b0;
    else if (flush)
      out_valid <= 1'b0;
    else if (load)
      out_valid <= in_valid;
  end

  // payload only moves with a real op, so a bubble
  // never disturbs the value held at the output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_shamt <= '0;
      out_mode  <= '0;
      out_tag   <= '0;
      out_sign  <= 1'b0;
    end else if (load && in_valid) begin
      out_data  <= shifted;
      out_shamt <= in_shamt;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      out_sign  <= in_sign;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: SLL/SRL/SRA/ROR shifter, STAGES deep,
// valid/ready on both sides, tag sideband, sync flush.
// Ports: clock, reset (async high), flush, in_valid/
// in_ready/in_data/in_shamt/in_mode/in_tag, out_valid/
// out_ready/out_data/out_tag.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int STAGES  = 2,
  parameter  int TAG_W   = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic               v_q [STAGES];
  logic [WIDTH-1:0]   d_q [STAGES];
  logic [SHAMT_W-1:0] s_q [STAGES];
  logic [1:0]         m_q [STAGES];
  logic [TAG_W-1:0]   t_q [STAGES];
  logic               g_q [STAGES];
  logic [STAGES-1:0]  load;

  // walk from the output back so each stage sees
  // whether the one ahead of it is moving
  always_comb begin
    logic adv;
    load = '0;
    adv  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !v_q[k] || adv;
      adv     = load[k];
    end
  end

  assign in_ready = load[0] && !flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic               vi;
    logic [WIDTH-1:0]   di;
    logic [SHAMT_W-1:0] si;
    logic [1:0]         mi;
    logic [TAG_W-1:0]   ti;
    logic               gi;

    if (k == 0) begin : g_head
      assign vi = in_valid && in_ready;
      assign di = in_data;
      assign si = in_shamt;
      assign mi = in_mode;
      assign ti = in_tag;
      assign gi = in_data[WIDTH-1];
    end else begin : g_body
      assign vi = v_q[k-1];
      assign di = d_q[k-1];
      assign si = s_q[k-1];
      assign mi = m_q[k-1];
      assign ti = t_q[k-1];
      assign gi = g_q[k-1];
    end

    shift_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .LEVEL_LO (level_lo(k, STAGES, SHAMT_W)),
      .LEVEL_HI (level_hi(k, STAGES, SHAMT_W))
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .load      (load[k]),
      .in_valid  (vi),
      .in_data   (di),
      .in_shamt  (si),
      .in_mode   (mi),
      .in_tag    (ti),
      .in_sign   (gi),
      .out_valid (v_q[k]),
      .out_data  (d_q[k]),
      .out_shamt (s_q[k]),
      .out_mode  (m_q[k]),
      .out_tag   (t_q[k]),
      .out_sign  (g_q[k])
    );
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_tag   = t_q[STAGES-1];

  logic unused_tail;
  assign unused_tail = ^{s_q[STAGES-1],
                         m_q[STAGES-1],
                         g_q[STAGES-1]};

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined, multi-mode shifter for the ALU and its future wide datapaths.
- Supersedes the combinational arithmetic-right barrel shifter:
  - adds SLL/SRL/SRA/ROR modes
  - configurable width and pipeline depth
  - valid/ready flow control with back-pressure
  - a sideband tag carried through the pipe
  - synchronous flush for branch mispredict
- Sits between issue and writeback of the shift/rotate execution lane.

Parameters:
- WIDTH, 32, data width; power of two, 8..64.
- STAGES, 2, register stages (latency); 1 <= STAGES <= log2(WIDTH).
- TAG_W, 5, sideband tag width (destination register id).
- Derived localparam SHAMT_W = log2(WIDTH); not overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  shifter can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount (0..WIDTH-1).
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  passthrough sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of out_data.

Behaviour:
- Clock, reset and handshakes:
  - One clock; reset is asynchronous and active-high.
  - Reset asserted: all stage valids, out_valid, out_data and out_tag are cleared to 0 immediately, independent of clock.
  - Handshake: transfer on valid && ready at a rising edge. in_valid/in_data may change only after acceptance; no combinational in_valid->in_ready path.
  - Stage k register loads when it is empty or stage k+1 loads (bubble collapsing). The last stage loads when empty or out_ready=1.
  - in_ready = (stage 0 empty || stage 0 advances) && !flush.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid with no stall.
  - Throughput is 1 op/cycle.
- Stall:
  - out_valid=1 && out_ready=0 holds out_data/out_tag stable.
  - Upstream stages fill bubbles, then in_ready drops.
  - No op is lost or duplicated.
- Shift levels:
  - Level i (shift by 2^i, i = 0..SHAMT_W-1) is applied in stage floor(i*STAGES/SHAMT_W). For defaults: levels 0-2 in stage 0, levels 3-4 in stage 1.
  - Mode, remaining shamt bits and tag are pipelined alongside the data.
- Arithmetic:
  - SLL zero-fills LSBs. SRL zero-fills MSBs. SRA replicates the original in_data[WIDTH-1]. ROR rotates right.
  - Results are truncated to WIDTH.
  - shamt=0 returns in_data unchanged in all modes.
  - shamt=WIDTH-1 SRA yields all-ones or all-zeros per sign.
- Flush:
  - At the edge, clears all stage valids, including an output that is not yet accepted.
  - An op presented the same cycle is not accepted (in_ready=0).
  - Flush has priority over stall. The cycle after flush, in_ready=1.
- Reset mid-operation: in-flight ops are discarded, and no out_valid is produced for them after reset deasserts.
- out_data/out_tag are don't-care while out_valid=0, but stay 0 from reset until the first result.

Decomposition:
- Package shifter_pkg:
  - mode encodings MODE_SLL/MODE_SRL/MODE_SRA/MODE_ROR (2-bit)
  - a function computing the stage index for a level
- Sub-module shift_stage, instantiated STAGES times via generate:
  - parameters WIDTH, TAG_W, LEVEL_LO, LEVEL_HI
  - combinational levels LEVEL_LO..LEVEL_HI followed by one valid/data/tag/mode/shamt/sign register with load enable
- Top level holds the handshake/flush logic only.

Test Plan:
- Sweep, no stall: in_data=0xFFFE7938 (-100040), mode SRA, shamt 0..31 back-to-back -> out_valid 2 cycles after each accept, one result per cycle. Expected values: shamt4 -> 0xFFFFE793, shamt31 -> 0xFFFFFFFF, shamt0 -> 0xFFFE7938.
- Modes on 0xFFFE7938:
  - SRL 4 -> 0x0FFFE793
  - SLL 3 -> 0xFFF3C9C0
  - ROR 8 -> 0x38FFFE79
  - SLL 31 of 0x00000001 -> 0x80000000
  - tags 1,2,3,4 returned in order
- Back-pressure: out_ready=0 for 5 cycles during a 6-op burst -> out_data constant while stalled, in_ready falls after 2 further accepts, all 6 results emerge in order with no duplicates.
- Flush: flush asserted with 2 ops in flight and in_valid=1 -> next cycle out_valid=0, the presented op is not accepted, and a later op (tag 7, SRL 1 of 0x2) yields 0x1 with tag 7.
- Async reset mid-burst: reset pulsed between clock edges -> out_valid=0 immediately, and no stale results appear after release.
- Parameter sweep: WIDTH=64/STAGES=3 and WIDTH=8/STAGES=1 with a random 2000-op run with random out_ready -> every result matches a $signed/$unsigned shift/rotate reference model, with latency = STAGES when unstalled.
